// File: rtl/con12to8.sv
// Three-digit BCD to 8-bit binary converter using reverse double-dabble,
// with an offset subtraction and saturating, flagged output.
module con12to8 #(
    parameter logic [7:0] OFFSET = 8'd5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] bcdin,
    output logic [7:0]  binout,
    output logic        busy,
    output logic        done,
    output logic        err_digit,
    output logic        ovf,
    output logic        unf
);

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    typedef struct packed {
        logic [7:0] bin;
        logic       err;
        logic       ovf;
        logic       unf;
    } res_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [21:0] sreg_q;
    logic [21:0] sreg_d;
    logic        bad_q;
    res_t        res_d;

    // One reverse double-dabble step: shift right, then correct each BCD nibble.
    function automatic logic [21:0] shift_step(input logic [21:0] r);
        logic [21:0] s;
        s = r >> 1;
        if (s[21:18] >= 4'd8) s[21:18] = s[21:18] - 4'd3;
        if (s[17:14] >= 4'd8) s[17:14] = s[17:14] - 4'd3;
        if (s[13:10] >= 4'd8) s[13:10] = s[13:10] - 4'd3;
        return s;
    endfunction

    function automatic logic bad_digit(input logic [11:0] b);
        return (b[11:8] > 4'd9) || (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
    endfunction

    // Offset subtraction with saturation; a bad digit overrides everything.
    function automatic res_t select_result(input logic [9:0] bin, input logic err);
        logic signed [10:0] diff;
        res_t r;
        diff = $signed({1'b0, bin}) - $signed({3'b000, OFFSET});
        r = '0;
        if (err) begin
            r.err = 1'b1;
        end else if (diff < 11'sd0) begin
            r.unf = 1'b1;
        end else if (diff > 11'sd255) begin
            r.bin = 8'hFF;
            r.ovf = 1'b1;
        end else begin
            r.bin = diff[7:0];
        end
        return r;
    endfunction

    always_comb begin
        sreg_d = shift_step(sreg_q);
        res_d  = select_result(sreg_q[9:0], bad_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            sreg_q    <= 22'd0;
            bad_q     <= 1'b0;
            binout    <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_digit <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sreg_q  <= {bcdin, 10'd0};
                        cnt_q   <= 4'd0;
                        bad_q   <= bad_digit(bcdin);
                        busy    <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    sreg_q <= sreg_d;
                    cnt_q  <= cnt_q + 4'd1;
                    if (cnt_q == 4'd9) state_q <= FINISH;
                end
                FINISH: begin
                    binout    <= res_d.bin;
                    err_digit <= res_d.err;
                    ovf       <= res_d.ovf;
                    unf       <= res_d.unf;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_con12to8.sv
// Directed bench for con12to8: a cycle-level behavioural model checked every
// cycle, plus hand-computed expectations for each directed conversion.
module tb_con12to8;

    localparam int OFFSET = 5;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [11:0] bcdin;
    logic [7:0]  binout;
    logic        busy, done, err_digit, ovf, unf;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    con12to8 #(.OFFSET(8'(OFFSET))) dut (
        .clk(clk), .reset(reset), .start(start), .bcdin(bcdin),
        .binout(binout), .busy(busy), .done(done),
        .err_digit(err_digit), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Decimal decode, offset and saturation straight from the output rules.
    function automatic void model_out(input logic [11:0] b, output int o,
                                      output int e, output int ov, output int un);
        int h, t, u, d;
        h = int'(b[11:8]); t = int'(b[7:4]); u = int'(b[3:0]);
        e = (h > 9 || t > 9 || u > 9) ? 1 : 0;
        d = 100 * h + 10 * t + u - OFFSET;
        o = 0; ov = 0; un = 0;
        if (e == 1) o = 0;
        else if (d < 0) un = 1;
        else if (d > 255) begin o = 255; ov = 1; end
        else o = d;
    endfunction

    // Model: an accepted request yields its result exactly 11 edges later.
    int m_bin, m_err, m_ovf, m_unf, m_busy, m_done;
    int remaining;
    bit active = 0;
    logic [11:0] cap;

    always @(posedge clk) begin
        if (reset) begin
            m_bin = 0; m_err = 0; m_ovf = 0; m_unf = 0; m_busy = 0; m_done = 0;
            active = 0;
        end else begin
            m_done = 0;
            if (active) begin
                remaining--;
                if (remaining == 0) begin
                    active = 0;
                    model_out(cap, m_bin, m_err, m_ovf, m_unf);
                    m_done = 1;
                end
            end else if (start) begin
                active = 1;
                remaining = 11;
                cap = bcdin;
            end
            m_busy = active ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_done", int'(done), m_done);
            chk("cyc_busy", int'(busy), m_busy);
            chk("cyc_binout", int'(binout), m_bin);
            chk("cyc_err", int'(err_digit), m_err);
            chk("cyc_ovf", int'(ovf), m_ovf);
            chk("cyc_unf", int'(unf), m_unf);
        end
    end

    task automatic run_conv(input logic [11:0] b, input int eb, input int ee,
                            input int eo, input int eu);
        int n;
        bit got;
        @(posedge clk); #2; start = 1'b1; bcdin = b;
        @(posedge clk); #2; start = 1'b0; bcdin = b ^ 12'h5A5;
        n = 0; got = 0;
        while (!got && n < 20) begin
            @(negedge clk); n++;
            if (done) got = 1;
        end
        chk("latency", n - 1, 11);
        chk("res_binout", int'(binout), eb);
        chk("res_err", int'(err_digit), ee);
        chk("res_ovf", int'(ovf), eo);
        chk("res_unf", int'(unf), eu);
    endtask

    initial begin
        int dcnt, d1, d2, bin_at_done;
        reset = 1'b1; start = 1'b0; bcdin = 12'd0;
        @(posedge clk); #2; chk_en = 1;
        @(posedge clk); #2; reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_binout", int'(binout), 0);

        run_conv(12'h128, 123, 0, 0, 0);
        run_conv(12'h260, 255, 0, 0, 0);
        run_conv(12'h261, 255, 0, 1, 0);
        run_conv(12'h999, 255, 0, 1, 0);
        run_conv(12'h003, 0, 0, 0, 1);
        run_conv(12'h005, 0, 0, 0, 0);
        run_conv(12'h1A0, 0, 1, 0, 0);

        // Second start mid-conversion must be ignored.
        @(posedge clk); #2; start = 1'b1; bcdin = 12'h050;
        @(posedge clk); #2; start = 1'b0;
        repeat (3) @(posedge clk);
        #2; start = 1'b1; bcdin = 12'h777;
        @(posedge clk); #2; start = 1'b0;
        dcnt = 0; bin_at_done = -1;
        repeat (15) begin
            @(negedge clk);
            if (done) begin dcnt++; bin_at_done = int'(binout); end
        end
        chk("ign_done_count", dcnt, 1);
        chk("ign_binout", bin_at_done, 45);

        // Start held high: restart in every done cycle, 12-cycle cadence.
        @(posedge clk); #2; start = 1'b1; bcdin = 12'h128;
        d1 = -1; d2 = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                if (d1 < 0) d1 = i;
                else if (d2 < 0) d2 = i;
            end
        end
        chk("b2b_period", d2 - d1, 12);
        @(posedge clk); #2; start = 1'b0;
        repeat (15) @(negedge clk);

        // Reset aborts an in-flight conversion.
        @(posedge clk); #2; start = 1'b1; bcdin = 12'h128;
        @(posedge clk); #2; start = 1'b0;
        repeat (4) @(posedge clk);
        #2; reset = 1'b1;
        @(posedge clk); #2; reset = 1'b0;
        @(negedge clk);
        chk("abort_binout", int'(binout), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        dcnt = 0;
        repeat (15) begin @(negedge clk); if (done) dcnt++; end
        chk("abort_no_done", dcnt, 0);
        run_conv(12'h050, 45, 0, 0, 0);

        // Start coincident with reset is dropped.
        @(posedge clk); #2; reset = 1'b1; start = 1'b1; bcdin = 12'h128;
        @(posedge clk); #2; reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", int'(busy), 0);
        dcnt = 0;
        repeat (14) begin @(negedge clk); if (done) dcnt++; end
        chk("rst_start_no_done", dcnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/con12to8.md
CON12TO8 -- requirements
Module: con12to8

Interface
REQ-001 The module SHALL have parameter OFFSET, default 5: 8-bit unsigned value subtracted from the decoded BCD value before output.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit: conversion request, sampled on the clk edge.
REQ-005 The module SHALL have port bcdin, input, 12 bits: [11:8] hundreds, [7:4] tens, [3:0] ones.
REQ-006 The module SHALL have port binout, output, 8 bits: registered binary result.
REQ-007 The module SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-008 The module SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-009 The module SHALL have port err_digit, output, 1 bit: at least one captured nibble exceeded 9.
REQ-010 The module SHALL have port ovf, output, 1 bit: decoded value minus OFFSET exceeded 255.
REQ-011 The module SHALL have port unf, output, 1 bit: decoded value was less than OFFSET.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and FINISH.
REQ-013 In IDLE with start=1 at edge E0, the FSM SHALL capture bcdin into a 22-bit register {bcd[11:0], bin[9:0]=0}, clear a 4-bit iteration counter, set busy=1 and enter SHIFT.
REQ-014 In SHIFT at each of edges E1..E10, the FSM SHALL shift the 22-bit register right by 1, then subtract 3 from every BCD nibble that is >=8, then increment the counter.
REQ-015 The FSM SHALL go from SHIFT to FINISH at the edge where the counter reaches 10 (E10).
REQ-016 At E11 in FINISH, the FSM SHALL register the outputs, set done=1 and busy=0, and return to IDLE.
REQ-017 The latency SHALL be fixed: done is high in the cycle after E11, for exactly one cycle, regardless of data or errors.
REQ-018 Arithmetic SHALL use an 11-bit signed difference: diff = bin[9:0] - OFFSET.
REQ-019 Output select SHALL be as follows: err_digit -> binout=0, ovf=0, unf=0; else diff<0 -> binout=0, unf=1; else diff>255 -> binout=255, ovf=1; else binout=diff[7:0].
REQ-020 err_digit SHALL be evaluated on the value captured at E0; the conversion still runs the full 10 iterations.
REQ-021 binout, err_digit, ovf and unf SHALL hold their values until the next FINISH or reset.
REQ-022 The module SHALL ignore start while busy=1 (SHIFT and FINISH), and SHALL ignore bcdin changes after capture.
REQ-023 start=1 in the cycle where done=1 (state IDLE) SHALL be accepted: back-to-back conversions every 12 cycles.
REQ-024 Maximum legal input 0x999 decodes to 999; the 10-bit accumulator SHALL NOT wrap.

Reset
REQ-025 reset=1 at a clk edge SHALL force IDLE, counter=0, shift register=0, binout=0, busy=0, done=0, err_digit=0, ovf=0 and unf=0.
REQ-026 Reset SHALL take priority over start and over any in-flight conversion; an aborted conversion SHALL NOT produce a done pulse.
REQ-027 start asserted in the same cycle as reset SHALL be ignored.

Verification
REQ-028 Reset, then start with bcdin=0x128 and OFFSET=5 SHALL give done exactly 11 cycles after the start edge with binout=123 and all flags 0.
REQ-029 bcdin=0x260 SHALL give binout=255 with ovf=0; bcdin=0x261 SHALL give binout=255 with ovf=1; bcdin=0x999 SHALL give binout=255 with ovf=1.
REQ-030 bcdin=0x003 SHALL give binout=0 with unf=1; bcdin=0x005 SHALL give binout=0 with unf=0.
REQ-031 bcdin=0x1A0 SHALL give err_digit=1 and binout=0 after the same 11-cycle latency.
REQ-032 start pulsed again at cycle 4 of a 0x050 conversion with bcdin=0x777 SHALL be ignored, giving a single done with binout=45; start held high SHALL restart in the done cycle.
REQ-033 reset asserted at cycle 5 of a conversion SHALL give all outputs 0 next cycle, no done pulse, and a fresh start that completes normally.
